// File: rtl/coreahbtoapb3_ctrl.sv
// rtl/coreahbtoapb3_ctrl.sv - AHB-Lite to APB3 bridge sequencing FSM
//
// Purpose: accepts AHB-Lite slave transfers, sequences APB3 SETUP/ACCESS,
// drives the address/write-data/read-data strobes of the bridge datapath
// and returns HREADYOUT/HRESP, including the two-cycle AHB ERROR response.
//
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   HSEL, HTRANS, HWRITE,
//   HREADY                  AHB address-phase inputs
//   HREADYOUT, HRESP        AHB slave response (registered)
//   PSEL, PENABLE, PWRITE   APB3 control (registered)
//   PREADY, PSLVERR         APB3 completion inputs
//   addr_ld                 combinational pulse on an accepted address phase
//   wdata_ld                registered pulse during the write data phase
//   rdata_cap               combinational pulse on a completing APB read

module coreahbtoapb3_ctrl #(
    parameter int APB_TIMEOUT = 0,
    parameter int TMO_WIDTH   = 8
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic       HWRITE,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    input  logic       PREADY,
    input  logic       PSLVERR,
    output logic       addr_ld,
    output logic       wdata_ld,
    output logic       rdata_cap
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4,
        ERR1   = 3'd5,
        ERR2   = 3'd6
    } state_t;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    state_t               r_state;
    logic                 r_hreadyout;
    logic                 r_hresp;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic                 r_wdata_ld;
    logic [TMO_WIDTH-1:0] r_tmo;

    logic w_accept_state;
    logic w_trans_active;
    logic w_start;
    logic w_timeout;

    // Only states where the AHB data phase is free may take a new address phase.
    assign w_accept_state = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR2);
    assign w_trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign w_start        = HSEL && w_trans_active && HREADY && w_accept_state && !HRESET;

    assign w_timeout = (APB_TIMEOUT != 0) && (r_tmo == TMO_WIDTH'(APB_TIMEOUT));

    assign addr_ld   = w_start;
    assign rdata_cap = (r_state == ACCESS) && PREADY && !r_pwrite && !HRESET;
    assign wdata_ld  = r_wdata_ld;

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_wdata_ld  <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_wdata_ld <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR2: begin
                    if (w_start) begin
                        r_pwrite    <= HWRITE;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b0;
                        if (HWRITE) begin
                            r_state    <= WDATA;
                            r_wdata_ld <= 1'b1;
                        end else begin
                            r_state <= SETUP;
                            r_psel  <= 1'b1;
                        end
                    end else begin
                        r_state     <= IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
                WDATA: begin
                    r_state <= SETUP;
                    r_psel  <= 1'b1;
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY || w_timeout) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_tmo     <= '0;
                        // A timeout is only reached with PREADY low, so PSLVERR
                        // is qualified by PREADY here.
                        if (!PREADY || PSLVERR) begin
                            r_state <= ERR1;
                            r_hresp <= 1'b1;
                        end else begin
                            r_state     <= DONE;
                            r_hreadyout <= 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + TMO_WIDTH'(1);
                    end
                end
                ERR1: begin
                    r_state     <= ERR2;
                    r_hreadyout <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_tmo       <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/coreahbtoapb3_ctrl.md
Name: coreahbtoapb3_ctrl

Overview:
- Sequencing FSM for the AHB-Lite to APB3 bridge.
- Accepts AHB-Lite slave transfers, generates APB3 PSEL/PENABLE/PWRITE timing, and drives the load/capture strobes of the bridge address/data register datapath.
- Generates HREADYOUT/HRESP, including the two-cycle AHB ERROR response for PSLVERR and for APB timeout.
- Sits between the AHB slave port and the address/data register block.

Parameters:
- APB_TIMEOUT, 0: maximum ACCESS cycles waiting for PREADY before forcing an error; 0 disables the timeout.
- TMO_WIDTH, 8: width of the timeout counter; APB_TIMEOUT must be < 2^TMO_WIDTH.

Ports:
- HCLK  in  1  bridge clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  AHB slave select.
- HTRANS  in  2  AHB transfer type; only NONSEQ (10) and SEQ (11) start transfers.
- HWRITE  in  1  AHB direction.
- HREADY  in  1  AHB bus ready (address-phase qualifier).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.
- addr_ld  out  1  pulse: datapath loads HADDR into PADDR.
- wdata_ld  out  1  pulse: datapath loads HWDATA into PWDATA.
- rdata_cap  out  1  pulse: datapath loads PRDATA into HRDATA.

Behaviour:
- Interface fixed: one clock, HCLK; reset HRESET is synchronous and active-high.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, PWRITE=0, strobes=0, timeout counter=0.
- Reset asserted mid-transfer: PSEL and PENABLE drop at that edge. No completion or error is signalled.
- Valid address phase: start = HSEL & HTRANS[1] & HREADY. It is evaluated only in IDLE, DONE and ERR2. IDLE/BUSY HTRANS and HSEL=0 are ignored.
- On start, in the same cycle:
  - addr_ld=1 (combinational pulse);
  - PWRITE<=HWRITE;
  - next state = WDATA if HWRITE, else SETUP.
- States and registered outputs:
  - IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0. Goes to WDATA or SETUP on start, otherwise stays in IDLE.
  - WDATA: HREADYOUT=0; wdata_ld=1 this cycle (HWDATA is valid in the data phase). Goes to SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Goes to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. Waits for PREADY; the counter increments each cycle that PREADY=0. When PREADY=1:
    - rdata_cap=1 if PWRITE=0;
    - if PSLVERR=1, go to ERR1, else go to DONE.
  - Timeout: if APB_TIMEOUT>0, counter==APB_TIMEOUT and PREADY=0, go to ERR1 with no rdata_cap. The counter clears on leaving ACCESS.
  - DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Goes to WDATA or SETUP on start, otherwise IDLE.
  - ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1. Goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Start handling is identical to DONE; goes to IDLE if there is no start.
- Latency with zero-wait APB (PREADY=1 in the first ACCESS cycle):
  - read: address phase at cycle 0, SETUP c1, ACCESS c2, HREADYOUT=1 with valid HRDATA at c3;
  - write: address phase at c0, WDATA c1, SETUP c2, ACCESS c3, HREADYOUT=1 at c4.
- Pipelining: a start in DONE or ERR2 is accepted back-to-back with no idle cycle. The previous APB transfer has ended, so the PADDR overwrite is safe.
- PSLVERR is ignored unless PREADY=1 in ACCESS.
- PWRITE holds its value between transfers.

Test Plan:
- Single read at HADDR 0x100, PRDATA 0xDEADBEEF, PREADY=1 -> addr_ld at c0; PSEL=1/PENABLE=0 at c1; PENABLE=1 and rdata_cap at c2; HREADYOUT=1, HRESP=0 at c3; then IDLE.
- Single write 0x12345678, PREADY low for 3 ACCESS cycles -> wdata_ld at c1; PSEL/PENABLE/PWRITE held stable through ACCESS c3..c6; HREADYOUT=1 at c7.
- Read with PREADY=1, PSLVERR=1 -> rdata_cap at ACCESS; ERR1 HREADYOUT=0/HRESP=1; ERR2 HREADYOUT=1/HRESP=1; a back-to-back write start in ERR2 -> WDATA next cycle.
- APB_TIMEOUT=4, PREADY stuck 0 -> ACCESS lasts 5 cycles; PSEL drops; ERR1/ERR2 sequence; no rdata_cap.
- Two NONSEQ reads back-to-back (second address phase in DONE) -> second SETUP in the cycle after DONE; no IDLE gap; two rdata_cap pulses.
- HRESET asserted during ACCESS -> next edge PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0; HTRANS=BUSY with HSEL=1 afterwards -> stays in IDLE.
